// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer that sits between the UART receiver and the MMIO
// register block. Each byte the receiver strobes in is stored, and software
// drains the bytes oldest-first through the SBUF read path. The oldest byte is
// shown first-word-fall-through on o_rd_data. The block also reports the fill
// level, full/empty, a sticky overrun flag and a threshold interrupt.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_wr_data      received byte from the UART receiver
//   i_wr_valid     one-cycle push strobe from the receiver
//   i_rd_en        pop strobe from MMIO (one pop per asserted cycle)
//   o_rd_data      head byte, first-word-fall-through (valid when !o_empty)
//   o_empty        FIFO holds no bytes
//   o_full         FIFO holds DEPTH bytes
//   o_level        current byte count, 0..DEPTH
//   i_thresh       interrupt threshold (0 behaves as 1)
//   o_irq          level >= effective threshold
//   o_overrun      sticky: a byte was dropped because the FIFO was full
//   i_clr_overrun  clears o_overrun
//   i_flush        discards all contents
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_wr_data,
  input  logic             i_wr_valid,
  input  logic             i_rd_en,
  output logic [7:0]       o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTR_W:0]   o_level,
  input  logic [PTR_W:0]   i_thresh,
  output logic             o_irq,
  output logic             o_overrun,
  input  logic             i_clr_overrun,
  input  logic             i_flush
);

  // Count value that means "every entry occupied", sized to match r_count.
  localparam logic [PTR_W:0] LP_FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             r_overrun;

  logic             w_empty;
  logic             w_full;
  logic             w_popAcc;
  logic             w_pushAcc;
  logic             w_overrunEvt;
  logic [PTR_W:0]   w_effThresh;

  // Status flags come straight from the registered count, so no input has a
  // combinational path to them.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL_COUNT);

  // A pop only counts when data is present. A push is accepted when there is
  // room, or when the FIFO is full but a pop frees the head slot in the same
  // cycle. A flush overrides both, so a push during a flush is discarded
  // silently and does not count as an overrun.
  assign w_popAcc     = i_rd_en && !w_empty && !i_flush;
  assign w_pushAcc    = i_wr_valid && (!w_full || w_popAcc) && !i_flush;
  assign w_overrunEvt = i_wr_valid && w_full && !w_popAcc && !i_flush;

  // A threshold of zero would keep the interrupt asserted even when the FIFO
  // is empty, so it is promoted to one.
  assign w_effThresh = (i_thresh == '0) ? (PTR_W+1)'(1) : i_thresh;

  assign o_rd_data = r_mem[r_rdPtr];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_level   = r_count;
  assign o_irq     = (r_count >= w_effThresh);
  assign o_overrun = r_overrun;

  // Storage array. It has no reset because its contents only matter where
  // the pointers and count say they are live.
  always_ff @(posedge i_clk) begin
    if (w_pushAcc) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  // Pointers and count. The pointers wrap naturally at DEPTH because DEPTH is
  // a power of two. Flush returns everything to the post-reset position, so
  // the next byte lands at index 0 again.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushAcc) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popAcc) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushAcc, w_popAcc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun flag. A new drop in the same cycle as a clear request
  // wins, so software never loses the news of a drop that raced its clear.
  // Flush leaves the flag alone on purpose: the dropped byte is still lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_overrunEvt) begin
      r_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

endmodule
